// File: rtl/muldiv_sequencer.sv
// Iterative MIPS HI/LO multiply/divide: shift-add multiply, restoring divide.
// Define MULDIV_UNSIGNED_EN to add the Uns port for multu/divu.
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             Start,
  input  logic             Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
`ifdef MULDIV_UNSIGNED_EN
  input  logic             Uns,
`endif
  output logic             Busy,
  output logic             Done,
  output logic             DivZero,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIXUP,
    S_DONE
  } state_t;

  state_t               state_q;
  logic [CW-1:0]        cnt_q;
  logic [2*WIDTH-1:0]   prod_q;
  logic [2*WIDTH-1:0]   prod_d;
  logic [WIDTH-1:0]     opb_q;
  logic                 op_q;
  logic                 sa_q;
  logic                 sb_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 dz_q;
  logic [WIDTH-1:0]     hi_q;
  logic [WIDTH-1:0]     lo_q;

  logic                 uns;
  logic                 sa_in;
  logic                 sb_in;
  logic [WIDTH-1:0]     mag_a;
  logic [WIDTH-1:0]     mag_b;

`ifdef MULDIV_UNSIGNED_EN
  assign uns = Uns;
`else
  assign uns = 1'b0;
`endif

  assign sa_in = ~uns & A[WIDTH-1];
  assign sb_in = ~uns & B[WIDTH-1];
  assign mag_a = sa_in ? -A : A;
  assign mag_b = sb_in ? -B : B;

  // prod_q holds {acc, multiplier} for multiply, {remainder, quotient} for divide
  logic [WIDTH:0] add_s;
  logic [WIDTH:0] sh_s;
  logic [WIDTH:0] sub_s;

  always_comb begin
    add_s  = {1'b0, prod_q[2*WIDTH-1:WIDTH]}
           + (prod_q[0] ? {1'b0, opb_q} : '0);
    sh_s   = {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-1]};
    sub_s  = sh_s - {1'b0, opb_q};
    prod_d = prod_q;
    if (!op_q) begin
      prod_d = {add_s, prod_q[WIDTH-1:1]};
    end else if (!sub_s[WIDTH]) begin
      prod_d = {sub_s[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b1};
    end else begin
      prod_d = {sh_s[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b0};
    end
  end

  logic [2*WIDTH-1:0] neg_p;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   res_hi;
  logic [WIDTH-1:0]   res_lo;

  always_comb begin
    neg_p  = -prod_q;
    quo    = prod_q[WIDTH-1:0];
    rem    = prod_q[2*WIDTH-1:WIDTH];
    res_hi = '0;
    res_lo = '0;
    if (!op_q) begin
      res_hi = (sa_q ^ sb_q) ? neg_p[2*WIDTH-1:WIDTH] : rem;
      res_lo = (sa_q ^ sb_q) ? neg_p[WIDTH-1:0] : quo;
    end else begin
      res_hi = sa_q ? -rem : rem;
      res_lo = (sa_q ^ sb_q) ? -quo : quo;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      prod_q  <= '0;
      opb_q   <= '0;
      op_q    <= 1'b0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (Start) begin
            op_q   <= Op;
            sa_q   <= sa_in;
            sb_q   <= sb_in;
            opb_q  <= Op ? mag_b : mag_a;
            prod_q <= {{WIDTH{1'b0}}, (Op ? mag_a : mag_b)};
            cnt_q  <= '0;
            dz_q   <= 1'b0;
            if (Op && (B == '0)) begin
              dz_q    <= 1'b1;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              busy_q  <= 1'b1;
              state_q <= S_RUN;
            end
          end
        end
        S_RUN: begin
          prod_q <= prod_d;
          cnt_q  <= cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            state_q <= S_FIXUP;
          end
        end
        S_FIXUP: begin
          hi_q    <= res_hi;
          lo_q    <= res_lo;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= S_DONE;
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign Busy    = busy_q;
  assign Done    = done_q;
  assign DivZero = dz_q;
  assign Hi      = hi_q;
  assign Lo      = lo_q;

endmodule
